// File: rtl/freq_counter_pkg.sv
// Shared definitions for the frequency counter measurement sequencer.
//   state_t        : sequencer state encoding (also driven on dbg_state)
//   DEFAULT_PERIOD : gate period in clk cycles loaded at reset
//   CONV_TIMEOUT   : clk cycles allowed for the converter before giving up
package freq_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    CONVERT = 2'd2,
    LOAD    = 2'd3
  } state_t;

  localparam int DEFAULT_PERIOD = 1200;
  localparam int CONV_TIMEOUT   = 64;

endpackage

// File: rtl/freq_gate_timer.sv
// Loadable down-counter with zero flag. Used for the gate window length and
// for the converter timeout.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (wins over dec)
//   load_val   : reload value
//   dec        : decrement by one; holds at zero instead of wrapping
//   count      : current value
//   zero       : count == 0
module freq_gate_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/freq_measure_ctrl.sv
// Measurement sequencer: gate window -> BCD conversion -> display latch.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for enable; conv_error may be cleared here
//   COUNT   | gate window open, edge counter enabled for period cycles
//   CONVERT | converter started, waiting for conv_done or timeout
//   LOAD    | one-cycle display latch strobe, relaunch if still enabled
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   enable              : run back-to-back measurement windows while high
//   period_load/in      : update gate period (0 stored as 1), next window on
//   conv_done           : converter completion
//   edge_count_clr      : Mealy, high on the cycle a window is launched
//   edge_count_en       : gate window
//   conv_start          : one-cycle converter start
//   display_load        : one-cycle display latch strobe
//   active, dbg_state   : state != IDLE, encoded state
//   dbg_timer           : gate timer bits [2:0]
//   conv_error          : sticky converter timeout flag
module freq_measure_ctrl #(
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = freq_counter_pkg::DEFAULT_PERIOD,
  parameter int CONV_TIMEOUT   = freq_counter_pkg::CONV_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                period_load,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                conv_done,
  output logic                edge_count_clr,
  output logic                edge_count_en,
  output logic                conv_start,
  output logic                display_load,
  output logic                active,
  output logic [1:0]          dbg_state,
  output logic [2:0]          dbg_timer,
  output logic                conv_error
);

  import freq_counter_pkg::*;

  localparam int TO_W = $clog2(CONV_TIMEOUT) + 1;

  state_t              state;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] gate_count;
  logic [TO_W-1:0]     to_count;
  logic                gate_zero;
  logic                to_zero;
  logic                launch;
  logic                to_load;

  // A window is launched from IDLE or straight out of LOAD.
  assign launch         = ((state == IDLE) || (state == LOAD)) && enable && !reset;
  assign edge_count_clr = launch;
  assign to_load        = (state == COUNT) && enable && gate_zero;
  assign dbg_state      = state;
  assign dbg_timer      = gate_count[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      period_reg <= PERIOD_W'(DEFAULT_PERIOD);
    end else if (period_load) begin
      period_reg <= (period_in == '0) ? PERIOD_W'(1) : period_in;
    end
  end

  // Loaded with period-1 so COUNT lasts exactly period cycles (timer P-1 .. 0).
  freq_gate_timer #(.W(PERIOD_W)) u_gate_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (launch),
    .load_val (period_reg - PERIOD_W'(1)),
    .dec      (state == COUNT),
    .count    (gate_count),
    .zero     (gate_zero)
  );

  freq_gate_timer #(.W(TO_W)) u_conv_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (to_load),
    .load_val (TO_W'(CONV_TIMEOUT - 1)),
    .dec      (state == CONVERT),
    .count    (to_count),
    .zero     (to_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      edge_count_en <= 1'b0;
      conv_start    <= 1'b0;
      display_load  <= 1'b0;
      active        <= 1'b0;
      conv_error    <= 1'b0;
    end else begin
      conv_start   <= 1'b0;
      display_load <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state         <= COUNT;
            edge_count_en <= 1'b1;
            active        <= 1'b1;
          end else begin
            conv_error <= 1'b0;
          end
        end
        COUNT: begin
          if (!enable) begin
            state         <= IDLE;
            edge_count_en <= 1'b0;
            active        <= 1'b0;
          end else if (gate_zero) begin
            state         <= CONVERT;
            edge_count_en <= 1'b0;
            conv_start    <= 1'b1;
          end
        end
        CONVERT: begin
          // conv_start is high only on the first CONVERT cycle; a done
          // arriving together with the start belongs to a stale conversion.
          if (conv_done && !conv_start) begin
            state        <= LOAD;
            display_load <= 1'b1;
          end else if (to_zero) begin
            state      <= IDLE;
            active     <= 1'b0;
            conv_error <= 1'b1;
          end
        end
        LOAD: begin
          if (enable) begin
            state         <= COUNT;
            edge_count_en <= 1'b1;
          end else begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Randomized self-checking bench for freq_measure_ctrl. Stimulus and expected
// output timelines are built together window by window from the sequencing
// rules, then replayed against the DUT cycle by cycle.
module tb_freq_measure_ctrl;

  localparam int N       = 8192;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        period_load;
  logic [15:0] period_in;
  logic        conv_done;
  logic        edge_count_clr;
  logic        edge_count_en;
  logic        conv_start;
  logic        display_load;
  logic        active;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_timer;
  logic        conv_error;

  freq_measure_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .period_load    (period_load),
    .period_in      (period_in),
    .conv_done      (conv_done),
    .edge_count_clr (edge_count_clr),
    .edge_count_en  (edge_count_en),
    .conv_start     (conv_start),
    .display_load   (display_load),
    .active         (active),
    .dbg_state      (dbg_state),
    .dbg_timer      (dbg_timer),
    .conv_error     (conv_error)
  );

  always #5 clk = ~clk;

  // timeline: stimulus and expected {clr, en, start, load, active, state, err}
  logic        st_en   [N];
  logic        st_done [N];
  logic        st_pl   [N];
  logic [15:0] st_pv   [N];
  logic [7:0]  exp_out [N];
  int          exp_tmr [N];

  int          t;
  int          ld_t;
  logic [15:0] ld_v;
  int          model_period;
  bit          model_err;
  int          n_pass;
  int          n_total;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit rnd_noise();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic emit(input bit en, input bit done, input logic [1:0] st,
                      input bit clr, input bit cs, input bit dl, input int tmr);
    bit pl;
    pl         = (t == ld_t);
    st_en[t]   = en;
    st_done[t] = done;
    st_pl[t]   = pl;
    st_pv[t]   = ld_v;
    exp_out[t] = {clr, st == 2'd1, cs, dl, st != 2'd0, st, model_err};
    exp_tmr[t] = tmr;
    t++;
    if (pl) model_period = (ld_v == 16'd0) ? 1 : int'(ld_v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      emit(1'b0, rnd_noise(), 2'd0, 1'b0, 1'b0, 1'b0, -1);
      model_err = 1'b0;
    end
  endtask

  // d = cycles from conv_start to conv_done (0: converter never answers),
  // drop = COUNT cycle on which enable falls (0: never),
  // stay = keep enable high through LOAD so the next window follows directly.
  task automatic window(input bit from_idle, input int d, input int drop,
                        input bit stay, output bit ended_idle);
    int p;
    p = model_period;
    if (from_idle) emit(1'b1, rnd_noise(), 2'd0, 1'b1, 1'b0, 1'b0, -1);
    else           emit(1'b1, rnd_noise(), 2'd3, 1'b1, 1'b0, 1'b1, -1);
    for (int i = 1; i <= p; i++) begin
      if (i == drop) begin
        emit(1'b0, rnd_noise(), 2'd1, 1'b0, 1'b0, 1'b0, p - i);
        ended_idle = 1'b1;
        return;
      end
      emit(1'b1, rnd_noise(), 2'd1, 1'b0, 1'b0, 1'b0, p - i);
    end
    if (d == 0) begin
      for (int k = 1; k <= TIMEOUT; k++)
        emit(rnd_bit(), (k == 1) ? rnd_bit() : 1'b0, 2'd2, 1'b0, k == 1, 1'b0, -1);
      model_err  = 1'b1;
      ended_idle = 1'b1;
      return;
    end
    for (int k = 1; k <= d + 1; k++)
      emit(rnd_bit(), (k == d + 1) ? 1'b1 : ((k == 1) ? rnd_bit() : 1'b0),
           2'd2, 1'b0, k == 1, 1'b0, -1);
    if (stay) begin
      ended_idle = 1'b0;
    end else begin
      emit(1'b0, rnd_noise(), 2'd3, 1'b0, 1'b0, 1'b1, -1);
      ended_idle = 1'b1;
    end
  endtask

  task automatic run_timeline();
    int tv;
    for (int c = 0; c < t; c++) begin
      enable      = st_en[c];
      conv_done   = st_done[c];
      period_load = st_pl[c];
      period_in   = st_pv[c];
      @(negedge clk);
      chk($sformatf("trace@%0d", c),
          16'({edge_count_clr, edge_count_en, conv_start, display_load,
               active, dbg_state, conv_error}), 16'(exp_out[c]));
      if (exp_tmr[c] >= 0) begin
        tv = exp_tmr[c] & 7;
        chk($sformatf("timer@%0d", c), 16'(dbg_timer), 16'(tv));
      end
      @(posedge clk);
      #1;
    end
    enable      = 1'b0;
    conv_done   = 1'b0;
    period_load = 1'b0;
  endtask

  initial begin
    bit ie;
    int cnt;
    bit seen;
    n_pass = 0; n_total = 0;
    reset = 1'b1; enable = 1'b0; period_load = 1'b0; period_in = 16'd0; conv_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 16'({edge_count_clr, edge_count_en, conv_start, display_load,
                           active, dbg_state, conv_error}), 16'd0);
    chk("reset_timer", 16'(dbg_timer), 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    t = 0; ld_t = -1; ld_v = 16'd0; model_period = 1200; model_err = 1'b0;
    idle(2);
    // period 5, done 3 cycles after start, back-to-back windows
    ld_t = t; ld_v = 16'd5; idle(1);
    window(1'b1, 3, 0, 1'b1, ie);
    window(1'b0, 5, 0, 1'b0, ie);
    idle(2);
    // zero period stored as one
    ld_t = t; ld_v = 16'd0; idle(1);
    window(1'b1, 2, 0, 1'b1, ie);
    window(1'b0, 1, 0, 1'b0, ie);
    idle(1);
    // abort on 3rd COUNT cycle
    ld_t = t; ld_v = 16'd5; idle(1);
    window(1'b1, 4, 3, 1'b0, ie);
    idle(2);
    // converter timeout; error held through next window, cleared in IDLE
    window(1'b1, 0, 0, 1'b0, ie);
    window(1'b1, 4, 0, 1'b0, ie);
    idle(2);
    // period change mid-window applies to the following window
    ld_t = t + 3; ld_v = 16'd8;
    window(1'b1, 2, 0, 1'b1, ie);
    window(1'b0, 2, 0, 1'b0, ie);
    idle(1);
    // latest possible conv_done
    ld_t = t; ld_v = 16'd3; idle(1);
    window(1'b1, 63, 0, 1'b0, ie);
    idle(1);

    for (int n = 0; n < 25; n++) begin
      int nw;
      int d;
      int drop;
      if (t > N - 400) break;
      ld_t = t; ld_v = 16'($urandom_range(0, 12));
      idle($urandom_range(1, 3));
      nw = $urandom_range(1, 3);
      ie = 1'b1;
      for (int w = 0; w < nw; w++) begin
        d    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
        drop = ($urandom_range(0, 5) == 0) ? $urandom_range(1, model_period) : 0;
        if ($urandom_range(0, 2) == 0) begin
          ld_t = t + $urandom_range(0, 6);
          ld_v = 16'($urandom_range(0, 12));
        end
        window(ie, d, drop, w < nw - 1, ie);
      end
      idle(1);
    end
    run_timeline();

    // reset while in CONVERT
    t = 0; ld_t = 0; ld_v = 16'd5; model_err = 1'b0;
    idle(1);
    emit(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, -1);
    for (int i = 1; i <= 5; i++) emit(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 5 - i);
    emit(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, -1);
    emit(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, -1);
    run_timeline();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", 16'({edge_count_clr, edge_count_en, conv_start, display_load,
                             active, dbg_state, conv_error}), 16'd0);
    chk("rst_mid_timer", 16'(dbg_timer), 16'd0);
    conv_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_load", 16'({display_load, active, dbg_state}), 16'd0);
    end
    conv_done = 1'b0;

    // period after reset is the default
    enable = 1'b1;
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      @(negedge clk);
      if (edge_count_en) cnt++;
      if (conv_start) seen = 1'b1;
    end
    chk("default_period_start", 16'(seen), 16'd1);
    chk("default_period_len", 16'(cnt), 16'd1200);
    enable = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/freq_measure_ctrl.md
Name: freq_measure_ctrl

Overview:
Measurement sequencer for the frequency counter datapath. Opens a gate window of a programmable number of clk cycles, during which the external edge counter is enabled. It then starts the external binary-to-BCD converter and waits for completion. Finally it strobes the seven-segment display latch. It sits between the firmware/logic-analyzer configuration and the edge-counter/converter/display datapath, and drives the active and dbg_state pins.

Parameters:
PERIOD_W, 16, width of gate-period register and gate timer
DEFAULT_PERIOD, 1200, gate period (clk cycles) loaded at reset
CONV_TIMEOUT, 64, max clk cycles to wait for conv_done before abandoning conversion

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
enable  in  1  run continuous measurement windows while high
period_load  in  1  load period_in into gate-period register this cycle
period_in  in  PERIOD_W  new gate period in clk cycles
conv_done  in  1  converter finished (single-cycle pulse or level)
edge_count_clr  out  1  clear edge counter
edge_count_en  out  1  edge counter enable (gate window)
conv_start  out  1  one-cycle converter start pulse
display_load  out  1  one-cycle display latch strobe
active  out  1  high whenever state != IDLE
dbg_state  out  2  encoded state
dbg_timer  out  3  gate timer bits [2:0]
conv_error  out  1  sticky: converter timed out

Behaviour:
- Reset: state=IDLE, period_reg=DEFAULT_PERIOD, timer=0, conv_error=0. All strobes and active are low; dbg_state=0.
- States and encodings: IDLE=0, COUNT=1, CONVERT=2, LOAD=3.
- period_load may occur in any state and takes effect from the next window. A period_in of 0 is stored as 1. A window in progress keeps its loaded length.
- IDLE:
  - With enable=1: edge_count_clr=1 this cycle (combinational from state and enable), timer<=period_reg-1, next state COUNT.
  - With enable=0: remain in IDLE.
- COUNT:
  - edge_count_en=1 for exactly period_reg consecutive cycles.
  - The timer decrements each cycle; at timer==0 the next state is CONVERT.
  - If enable drops: abort, go to IDLE next cycle. No conv_start, no display_load.
- CONVERT:
  - conv_start=1 on the first CONVERT cycle only.
  - conv_done is sampled from the second CONVERT cycle onward; a conv_done coinciding with conv_start is ignored.
  - conv_done seen -> LOAD.
  - CONV_TIMEOUT cycles without conv_done -> conv_error<=1, go to IDLE, no display_load.
  - enable is ignored in this state; the conversion always completes or times out.
- LOAD: one cycle with display_load=1.
  - enable=1: edge_count_clr=1, timer reload, next state COUNT, so windows run back-to-back.
  - enable=0: next state IDLE.
- conv_error clears only on reset or when enable is low while in IDLE.
- Latency:
  - enable rising in IDLE -> first edge_count_en cycle is the next cycle.
  - Last edge_count_en -> conv_start is the next cycle.
  - conv_done -> display_load is the next cycle.
- Timing rules:
  - All state and counters are registered.
  - edge_count_clr is the only Mealy output; all other outputs are Moore, derived from registered state.
  - Timer and timeout counter do not wrap; both are reloaded on every state entry.
- reset mid-operation: return to IDLE on the next edge regardless of state. period_reg returns to DEFAULT_PERIOD.

Decomposition:
- Shared package freq_counter_pkg holds:
  - state typedef and encodings (IDLE/COUNT/CONVERT/LOAD)
  - DEFAULT_PERIOD
  - CONV_TIMEOUT
- One natural sub-module, freq_gate_timer: a loadable down-counter with zero flag, reused for the gate timer and the conversion timeout.
- The FSM stays in the top module.

Test Plan:
1. Reset, period_load with period_in=5, enable=1, conv_done returned 3 cycles after conv_start -> edge_count_clr one cycle; edge_count_en high exactly 5 cycles; conv_start one cycle later; display_load one cycle after conv_done; COUNT re-entered immediately; dbg_state sequence 0,1,2,3,1.
2. period_in=0 loaded, enable=1 -> edge_count_en high exactly 1 cycle per window.
3. enable dropped on the 3rd COUNT cycle of a 5-cycle window -> IDLE next cycle; active=0; no conv_start; no display_load.
4. conv_done never asserted, CONV_TIMEOUT=64 -> IDLE after 64 CONVERT cycles; conv_error=1 and held through the next window; clears after enable=0 in IDLE.
5. period_load with period_in=8 mid-window while period=5 -> current window 5 cycles, next window 8 cycles.
6. reset asserted in CONVERT -> next cycle: state IDLE, all outputs 0, period_reg=1200; conv_done arriving afterwards produces no display_load.
